// File: rtl/o_monitor_pkg.sv
// Shared types and constants for the O-output pattern monitor.
// PATTERN is the serial sequence the FSM detects, first-sampled bit in the MSB.
package o_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_11   = 2'd2,
        S_110  = 2'd3
    } mon_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/o_run_tracker.sv
// Previous-bit tracking, rising-edge detection and longest-run-of-ones tracking
// for the sampled O stream. All state updates only on enabled samples.
module o_run_tracker #(
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             rise_evt,
    output logic             rise,
    output logic [RUN_W-1:0] run_max
);

    localparam logic [RUN_W-1:0] RUN_TOP = '1;

    logic             prev_q, prev_d;
    logic             rise_q, rise_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_max_q, run_max_d;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        rise_evt  = en & ~clr & din & ~prev_q;
        run_inc   = (run_q == RUN_TOP) ? run_q : run_q + 1'b1;
        prev_d    = prev_q;
        rise_d    = 1'b0;
        run_d     = run_q;
        run_max_d = run_max_q;
        if (clr) begin
            prev_d    = 1'b0;
            run_d     = '0;
            run_max_d = '0;
        end else if (en) begin
            prev_d = din;
            rise_d = rise_evt;
            if (din) begin
                run_d = run_inc;
                // compare against the incremented run so run_max is current on this edge
                if (run_inc > run_max_q) begin
                    run_max_d = run_inc;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= 1'b0;
            rise_q    <= 1'b0;
            run_q     <= '0;
            run_max_q <= '0;
        end else begin
            prev_q    <= prev_d;
            rise_q    <= rise_d;
            run_q     <= run_d;
            run_max_q <= run_max_d;
        end
    end

    assign rise    = rise_q;
    assign run_max = run_max_q;

endmodule

// File: rtl/o_pattern_monitor.sv
// Monitor for the O output of sequential_circuit: overlapping 1101 detector,
// saturating match/rise counters with a sticky saturation flag, and 1-run tracking.
//
// state  | meaning
// S_IDLE | no useful prefix seen
// S_1    | last sampled bits end in 1
// S_11   | last sampled bits end in 11
// S_110  | last sampled bits end in 110; a 1 completes the pattern
module o_pattern_monitor
    import o_monitor_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             match,
    output logic             rise,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             cnt_sat,
    output logic [RUN_W-1:0] run_max
);

    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    mon_state_t       state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             cnt_sat_q, cnt_sat_d;
    logic             match_evt;
    logic             rise_evt;

    o_run_tracker #(
        .RUN_W (RUN_W)
    ) u_run_tracker (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .en       (en),
        .clr      (clr),
        .rise_evt (rise_evt),
        .rise     (rise),
        .run_max  (run_max)
    );

    always_comb begin
        state_d   = state_q;
        match_evt = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
        end else if (en) begin
            unique case (state_q)
                S_IDLE: state_d = din ? S_1 : S_IDLE;
                S_1:    state_d = din ? S_11 : S_IDLE;
                S_11:   state_d = din ? S_11 : S_110;
                S_110: begin
                    // overlap: the completing 1 is also the start of the next pattern
                    state_d   = din ? S_1 : S_IDLE;
                    match_evt = din;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        match_d     = match_evt;
        match_cnt_d = match_cnt_q;
        rise_cnt_d  = rise_cnt_q;
        cnt_sat_d   = cnt_sat_q;
        if (clr) begin
            match_cnt_d = '0;
            rise_cnt_d  = '0;
            cnt_sat_d   = 1'b0;
        end else begin
            if (match_evt && (match_cnt_q != CNT_TOP)) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
            if (rise_evt && (rise_cnt_q != CNT_TOP)) begin
                rise_cnt_d = rise_cnt_q + 1'b1;
            end
            cnt_sat_d = cnt_sat_q | (match_cnt_d == CNT_TOP) | (rise_cnt_d == CNT_TOP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
            rise_cnt_q  <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
            rise_cnt_q  <= rise_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = match_cnt_q;
    assign rise_cnt  = rise_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_o_pattern_monitor.sv
// Self-checking bench: vector table, hand-written corner sequences and random
// stimulus against a sample-history reference model, on default and 2-bit-counter instances.
module tb_o_pattern_monitor;
    import o_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;

    logic       match_a, rise_a, cnt_sat_a;
    logic [7:0] match_cnt_a, rise_cnt_a;
    logic [3:0] run_max_a;
    logic       match_b, rise_b, cnt_sat_b;
    logic [1:0] match_cnt_b, rise_cnt_b;
    logic [3:0] run_max_b;

    always #5 clk = ~clk;

    o_pattern_monitor dut (
        .clk(clk), .reset(reset), .din(din), .en(en), .clr(clr),
        .match(match_a), .rise(rise_a), .match_cnt(match_cnt_a),
        .rise_cnt(rise_cnt_a), .cnt_sat(cnt_sat_a), .run_max(run_max_a)
    );

    o_pattern_monitor #(.CNT_W(2), .RUN_W(4)) dut_s (
        .clk(clk), .reset(reset), .din(din), .en(en), .clr(clr),
        .match(match_b), .rise(rise_b), .match_cnt(match_cnt_b),
        .rise_cnt(rise_cnt_b), .cnt_sat(cnt_sat_b), .run_max(run_max_b)
    );

    int n_checks = 0;
    int n_err = 0;

    // reference model: history of samples since clear, totals and run lengths as plain integers
    bit hist[$];
    int m_total, r_total, cur_run, longest;
    bit m_match, m_rise;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        hist.delete();
        m_total = 0; r_total = 0; cur_run = 0; longest = 0;
        m_match = 0; m_rise = 0;
    endfunction

    function automatic void model_step(input bit d, input bit e, input bit c);
        bit prev;
        logic [3:0] last4;
        if (c) begin
            model_clear();
            return;
        end
        if (!e) begin
            m_match = 0; m_rise = 0;
            return;
        end
        prev = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        m_match = 0;
        if (hist.size() == 4) begin
            last4 = {hist[0], hist[1], hist[2], hist[3]};
            m_match = (last4 == PATTERN);
        end
        m_rise = d && !prev;
        if (m_match) m_total++;
        if (m_rise) r_total++;
        cur_run = d ? cur_run + 1 : 0;
        if (cur_run > longest) longest = cur_run;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".match"},     match_a,     m_match);
        chk({tag, ".rise"},      rise_a,      m_rise);
        chk({tag, ".match_cnt"}, match_cnt_a, sat(m_total, 255));
        chk({tag, ".rise_cnt"},  rise_cnt_a,  sat(r_total, 255));
        chk({tag, ".cnt_sat"},   cnt_sat_a,   (m_total >= 255 || r_total >= 255));
        chk({tag, ".run_max"},   run_max_a,   sat(longest, 15));
        chk({tag, ".s.match"},     match_b,     m_match);
        chk({tag, ".s.rise"},      rise_b,      m_rise);
        chk({tag, ".s.match_cnt"}, match_cnt_b, sat(m_total, 3));
        chk({tag, ".s.rise_cnt"},  rise_cnt_b,  sat(r_total, 3));
        chk({tag, ".s.cnt_sat"},   cnt_sat_b,   (m_total >= 3 || r_total >= 3));
        chk({tag, ".s.run_max"},   run_max_b,   sat(longest, 15));
    endtask

    // called with the clock low; returns at the following falling edge
    task automatic step(input logic d, input logic e, input logic c);
        din = d; en = e; clr = c;
        @(posedge clk);
        model_step(d, e, c);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic       d, e, c, m, r;
        logic [7:0] mc, rc;
        logic [3:0] rm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int d, e, c, m, r, mc, rc, rm);
        vec_t v;
        v.d = d[0]; v.e = e[0]; v.c = c[0]; v.m = m[0]; v.r = r[0];
        v.mc = mc[7:0]; v.rc = rc[7:0]; v.rm = rm[3:0];
        return v;
    endfunction

    initial begin
        //          din en clr | match rise mcnt rcnt runmax
        tbl.push_back(mk(0,0,1, 0,0,0,0,0));
        // overlapping 1101101
        tbl.push_back(mk(1,1,0, 0,1,0,1,1));
        tbl.push_back(mk(1,1,0, 0,0,0,1,2));
        tbl.push_back(mk(0,1,0, 0,0,0,1,2));
        tbl.push_back(mk(1,1,0, 1,1,1,2,2));
        tbl.push_back(mk(1,1,0, 0,0,1,2,2));
        tbl.push_back(mk(0,1,0, 0,0,1,2,2));
        tbl.push_back(mk(1,1,0, 1,1,2,3,2));
        // 1101 with enable gaps, din toggling while disabled
        tbl.push_back(mk(0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0, 0,1,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,1,1));
        tbl.push_back(mk(1,1,0, 0,0,0,1,2));
        tbl.push_back(mk(1,0,0, 0,0,0,1,2));
        tbl.push_back(mk(0,1,0, 0,0,0,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,1,2));
        tbl.push_back(mk(1,0,0, 0,0,0,1,2));
        tbl.push_back(mk(1,1,0, 1,1,1,2,2));
        tbl.push_back(mk(0,0,0, 0,0,1,2,2));
        // clear beats a completing bit
        tbl.push_back(mk(0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0, 0,1,0,1,1));
        tbl.push_back(mk(1,1,0, 0,0,0,1,2));
        tbl.push_back(mk(0,1,0, 0,0,0,1,2));
        tbl.push_back(mk(1,1,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0, 0,1,0,1,1));
        tbl.push_back(mk(1,1,0, 0,0,0,1,2));
        tbl.push_back(mk(0,1,0, 0,0,0,1,2));
        tbl.push_back(mk(1,1,0, 1,1,1,2,2));

        // reset held with din=1, en=1
        model_clear();
        reset = 1'b0; din = 1'b1; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst.match", match_a, 0);
        chk("rst.rise", rise_a, 0);
        chk("rst.match_cnt", match_cnt_a, 0);
        chk("rst.rise_cnt", rise_cnt_a, 0);
        chk("rst.cnt_sat", cnt_sat_a, 0);
        chk("rst.run_max", run_max_a, 0);
        chk("rst.state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b1;
        step(1, 1, 0);
        chk("first.rise", rise_a, 1);
        chk("first.rise_cnt", rise_cnt_a, 1);
        cmp_all("first");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].d, tbl[i].e, tbl[i].c);
            chk($sformatf("vec%0d.match", i), match_a, tbl[i].m);
            chk($sformatf("vec%0d.rise", i), rise_a, tbl[i].r);
            chk($sformatf("vec%0d.match_cnt", i), match_cnt_a, tbl[i].mc);
            chk($sformatf("vec%0d.rise_cnt", i), rise_cnt_a, tbl[i].rc);
            chk($sformatf("vec%0d.run_max", i), run_max_a, tbl[i].rm);
            cmp_all($sformatf("vec%0d", i));
        end

        // saturation: four rising edges on the 2-bit counters, then a long run of ones
        step(0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0);
            cmp_all("sat0");
            step(1, 1, 0);
            chk($sformatf("sat.rise%0d", k), rise_b, 1);
            chk($sformatf("sat.rise_cnt%0d", k), rise_cnt_b, (k > 3) ? 3 : k);
            chk($sformatf("sat.cnt_sat%0d", k), cnt_sat_b, (k >= 3) ? 1 : 0);
            cmp_all("sat1");
        end
        for (int k = 0; k < 20; k++) step(1, 1, 0);
        chk("sat.run_max", run_max_a, 15);
        chk("sat.s.run_max", run_max_b, 15);
        chk("sat.s.cnt_sat_hold", cnt_sat_b, 1);
        cmp_all("run20");

        // asynchronous reset in the middle of 1,1,0
        step(0, 0, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        #3 reset = 1'b0;
        #1 reset = 1'b1;
        model_clear();
        chk("async.state", 32'(dut.state_q), 32'(S_IDLE));
        chk("async.run_max", run_max_a, 0);
        step(1, 1, 0);
        chk("async.match", match_a, 0);
        chk("async.state_s1", 32'(dut.state_q), 32'(S_1));
        cmp_all("async");

        // random stream against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
            cmp_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
